phi_result_collector: RTL and testbench

//  Downstream gather stage for the CMU_PHi* covariance-prediction channels.

---
 rtl/phi_result_collector.sv | 142 ++++++++++++++
 tb/tb_phi_result_collector.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phi_result_collector.sv
// Gathers one 64-bit result per CMU_PHi* channel per epoch and hands the packed set
// to the covariance write-back stage over valid/ready; flags channels that never deliver.
module phi_result_collector #(
    parameter int DBL_WIDTH = 64,
    parameter int NUM_CH    = 10,
    parameter int TIMEOUT   = 256,
    parameter int TW        = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*DBL_WIDTH-1:0] ch_data,
    output logic                        mat_valid,
    input  logic                        mat_ready,
    output logic [NUM_CH*DBL_WIDTH-1:0] mat_data,
    output logic [NUM_CH-1:0]           cap_mask,
    output logic                        busy,
    output logic                        err_timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;
    localparam logic [1:0] ST_ERROR   = 2'd3;

    logic [1:0]          state_reg, state_next;
    logic [NUM_CH-1:0]   vq_reg, vq_next;
    logic [NUM_CH-1:0]   cap_mask_reg, cap_mask_next;
    logic [TW-1:0]       timer_reg, timer_next;
    logic                mat_valid_reg, mat_valid_next;
    logic                err_timeout_reg, err_timeout_next;
    logic [DBL_WIDTH-1:0] slot_reg [NUM_CH];

    logic [NUM_CH-1:0]   cap;
    logic                full;
    logic                start_acc;
    logic                timer_last;

    // Rising edge of a channel's valid, first one per epoch only.
    assign cap        = (state_reg == ST_COLLECT) ? (ch_valid & ~vq_reg & ~cap_mask_reg) : '0;
    assign full       = &(cap_mask_reg | cap);
    assign timer_last = (timer_reg == TW'(TIMEOUT - 1));
    assign start_acc  = start & ((state_reg == ST_IDLE) || (state_reg == ST_ERROR) ||
                                 ((state_reg == ST_OUTPUT) && mat_ready));

    // Clearing vq on epoch start turns an already-high valid into a fresh edge.
    assign vq_next = start_acc ? '0 : ch_valid;

    always_comb begin
        state_next       = state_reg;
        cap_mask_next    = cap_mask_reg | cap;
        timer_next       = timer_reg;
        mat_valid_next   = mat_valid_reg;
        err_timeout_next = err_timeout_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_COLLECT;
                    cap_mask_next = '0;
                    timer_next    = '0;
                end
            end
            ST_COLLECT: begin
                timer_next = timer_reg + TW'(1);
                if (full) begin
                    state_next     = ST_OUTPUT;
                    mat_valid_next = 1'b1;
                end else if (timer_last) begin
                    state_next       = ST_ERROR;
                    err_timeout_next = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (mat_ready) begin
                    mat_valid_next = 1'b0;
                    if (start) begin
                        state_next    = ST_COLLECT;
                        cap_mask_next = '0;
                        timer_next    = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_next       = ST_COLLECT;
                    err_timeout_next = 1'b0;
                    cap_mask_next    = '0;
                    timer_next       = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            vq_reg          <= '0;
            cap_mask_reg    <= '0;
            timer_reg       <= '0;
            mat_valid_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            vq_reg          <= vq_next;
            cap_mask_reg    <= cap_mask_next;
            timer_reg       <= timer_next;
            mat_valid_reg   <= mat_valid_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    // Slots are only ever overwritten by a capture, so stale slots survive across epochs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap[i]) begin
                    slot_reg[i] <= ch_data[i*DBL_WIDTH +: DBL_WIDTH];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_pack
            assign mat_data[gi*DBL_WIDTH +: DBL_WIDTH] = slot_reg[gi];
        end
    endgenerate

    assign mat_valid   = mat_valid_reg;
    assign cap_mask    = cap_mask_reg;
    assign err_timeout = err_timeout_reg;
    assign busy        = (state_reg == ST_COLLECT) || (state_reg == ST_OUTPUT);

endmodule

// File: tb/tb_phi_result_collector.sv
// Directed bench for phi_result_collector: capture, first-edge-wins, held levels,
// timeout recovery, output back-pressure and asynchronous reset.
module tb_phi_result_collector;

    localparam int DW = 64;
    localparam int NC = 10;
    localparam int TO = 16;
    localparam int TWB = 5;
    localparam int VW = NC * DW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NC-1:0] ch_valid;
    logic [VW-1:0] ch_data;
    logic          mat_valid;
    logic          mat_ready;
    logic [VW-1:0] mat_data;
    logic [NC-1:0] cap_mask;
    logic          busy;
    logic          err_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    logic [VW-1:0] exp_md;
    logic [DW-1:0] t1_val [NC];

    phi_result_collector #(
        .DBL_WIDTH(DW),
        .NUM_CH(NC),
        .TIMEOUT(TO),
        .TW(TWB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .ch_valid(ch_valid),
        .ch_data(ch_data),
        .mat_valid(mat_valid),
        .mat_ready(mat_ready),
        .mat_data(mat_data),
        .cap_mask(cap_mask),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic put(input int idx, input logic [DW-1:0] v);
        ch_data[idx*DW +: DW] = v;
    endtask

    initial begin
        t1_val[0] = 64'h3FF0_0000_0000_0000;
        t1_val[1] = 64'h4000_0000_0000_0000;
        t1_val[2] = 64'h4008_0000_0000_0000;
        t1_val[3] = 64'h4010_0000_0000_0000;
        t1_val[4] = 64'h4014_0000_0000_0000;
        t1_val[5] = 64'h4018_0000_0000_0000;
        t1_val[6] = 64'h401C_0000_0000_0000;
        t1_val[7] = 64'h4020_0000_0000_0000;
        t1_val[8] = 64'h4022_0000_0000_0000;
        t1_val[9] = 64'h4024_0000_0000_0000;

        rst_n = 1'b0;
        start = 1'b0;
        ch_valid = '0;
        ch_data = '0;
        mat_ready = 1'b0;
        exp_md = '0;
        #2;
        chk("rst_mat_valid", VW'(mat_valid), VW'(0));
        chk("rst_mat_data", mat_data, '0);
        chk("rst_cap_mask", VW'(cap_mask), VW'(0));
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_err", VW'(err_timeout), VW'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // T1: all channels rise together
        for (int i = 0; i < NC; i++) begin
            put(i, t1_val[i]);
            exp_md[i*DW +: DW] = t1_val[i];
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ch_valid = '1;
        chk("t1_busy", VW'(busy), VW'(1));
        chk("t1_valid_early", VW'(mat_valid), VW'(0));
        tick();
        chk("t1_mat_valid", VW'(mat_valid), VW'(1));
        chk("t1_mat_data", mat_data, exp_md);
        chk("t1_cap_mask", VW'(cap_mask), VW'(10'h3FF));
        mat_ready = 1'b1;
        tick();
        mat_ready = 1'b0;
        ch_valid = '0;
        chk("t1_drain_valid", VW'(mat_valid), VW'(0));
        chk("t1_idle_busy", VW'(busy), VW'(0));
        tick();

        // T2: staggered rises 9..0, re-pulses ignored
        for (int i = 0; i < NC; i++) begin
            put(i, 64'hB000_0000_0000_0000 + 64'(i));
            exp_md[i*DW +: DW] = 64'hB000_0000_0000_0000 + 64'(i);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 9; k >= 1; k--) begin
            ch_valid[k] = 1'b1;
            if (k == 6) begin
                ch_valid[9] = 1'b0;
                put(9, 64'hDEAD_BEEF_0000_0009);
            end
            if (k == 5) ch_valid[9] = 1'b1;
            tick();
        end
        chk("t2_partial_mask", VW'(cap_mask), VW'(10'h3FE));
        chk("t2_partial_valid", VW'(mat_valid), VW'(0));
        ch_valid[0] = 1'b1;
        tick();
        chk("t2_mat_valid", VW'(mat_valid), VW'(1));
        chk("t2_mat_data", mat_data, exp_md);
        ch_valid[0] = 1'b0;
        tick();
        put(0, 64'hDEAD_BEEF_0000_0000);
        ch_valid[0] = 1'b1;
        tick();
        chk("t2_repulse_data", mat_data, exp_md);
        chk("t2_repulse_valid", VW'(mat_valid), VW'(1));
        mat_ready = 1'b1;
        tick();
        mat_ready = 1'b0;
        ch_valid = '0;
        chk("t2_idle_busy", VW'(busy), VW'(0));
        tick();

        // T3: valid already high before start
        for (int i = 0; i < NC; i++) begin
            put(i, 64'hC000_0000_0000_0000 + 64'(i));
            exp_md[i*DW +: DW] = 64'hC000_0000_0000_0000 + 64'(i);
        end
        ch_valid = '1;
        tick();
        tick();
        chk("t3_idle_ignore", VW'(busy), VW'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_collect_valid", VW'(mat_valid), VW'(0));
        tick();
        chk("t3_mat_valid", VW'(mat_valid), VW'(1));
        chk("t3_cap_mask", VW'(cap_mask), VW'(10'h3FF));
        chk("t3_mat_data", mat_data, exp_md);
        mat_ready = 1'b1;
        tick();
        mat_ready = 1'b0;
        ch_valid = '0;
        tick();

        // T4: channel 3 never delivers
        for (int i = 0; i < NC; i++) begin
            put(i, 64'hD000_0000_0000_0000 + 64'(i));
            if (i != 3) exp_md[i*DW +: DW] = 64'hD000_0000_0000_0000 + 64'(i);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ch_valid = 10'h3F7;
        for (int k = 1; k <= TO - 1; k++) tick();
        chk("t4_pre_err", VW'(err_timeout), VW'(0));
        chk("t4_pre_busy", VW'(busy), VW'(1));
        tick();
        chk("t4_err", VW'(err_timeout), VW'(1));
        chk("t4_err_busy", VW'(busy), VW'(0));
        chk("t4_err_valid", VW'(mat_valid), VW'(0));
        chk("t4_err_mask", VW'(cap_mask), VW'(10'h3F7));
        chk("t4_partial_data", mat_data, exp_md);
        tick();
        chk("t4_err_sticky", VW'(err_timeout), VW'(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart_err", VW'(err_timeout), VW'(0));
        chk("t4_restart_busy", VW'(busy), VW'(1));
        chk("t4_restart_mask", VW'(cap_mask), VW'(0));
        for (int i = 0; i < NC; i++) begin
            put(i, 64'hE000_0000_0000_0000 + 64'(i));
            exp_md[i*DW +: DW] = 64'hE000_0000_0000_0000 + 64'(i);
        end
        ch_valid = '1;
        tick();
        chk("t5_mat_valid", VW'(mat_valid), VW'(1));
        chk("t5_mat_data", mat_data, exp_md);

        // T5: back-pressure with input churn and a start without ready
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < NC; j++) put(j, {$urandom(), $urandom()});
            ch_valid = ~ch_valid;
            start = (i == 2);
            tick();
            chk("t5_hold_valid", VW'(mat_valid), VW'(1));
            chk("t5_hold_data", mat_data, exp_md);
        end
        chk("t5_hold_mask", VW'(cap_mask), VW'(10'h3FF));
        mat_ready = 1'b1;
        start = 1'b1;
        tick();
        mat_ready = 1'b0;
        start = 1'b0;
        ch_valid = '0;
        chk("t5_restart_valid", VW'(mat_valid), VW'(0));
        chk("t5_restart_busy", VW'(busy), VW'(1));
        chk("t5_restart_mask", VW'(cap_mask), VW'(0));

        // T6: asynchronous reset mid-epoch
        ch_valid = 10'h00F;
        tick();
        chk("t6_mask_0f", VW'(cap_mask), VW'(10'h00F));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mask", VW'(cap_mask), VW'(0));
        chk("t6_rst_busy", VW'(busy), VW'(0));
        chk("t6_rst_data", mat_data, '0);
        chk("t6_rst_valid", VW'(mat_valid), VW'(0));
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_idle_busy", VW'(busy), VW'(0));
        for (int i = 0; i < NC; i++) begin
            put(i, 64'hF000_0000_0000_0000 + 64'(i));
            exp_md[i*DW +: DW] = 64'hF000_0000_0000_0000 + 64'(i);
        end
        ch_valid = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_new_valid", VW'(mat_valid), VW'(1));
        chk("t6_new_mask", VW'(cap_mask), VW'(10'h3FF));
        chk("t6_new_data", mat_data, exp_md);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
